// File: rtl/data_mem_responder.sv
// Byte-addressable data memory responder with fixed response latency.
// One outstanding request; little-endian sized loads and stores.
module data_mem_responder #(
   parameter int DEPTH_BYTES = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [63:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_BYTES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t state, state_nx;
   logic [3:0] cnt, cnt_nx;

   logic        cap_we, cap_uns;
   logic [63:0] cap_addr, cap_wdata;
   logic [1:0]  cap_size;

   logic [7:0]  mem [DEPTH_BYTES];
   logic [63:0] rdata_q;
   logic        err_q;

   logic        accept, enter_resp;
   logic        cur_we, cur_uns;
   logic [63:0] cur_addr, cur_wdata;
   logic [1:0]  cur_size;
   logic [3:0]  nbytes;
   logic [64:0] end_addr;
   logic        misal, oor, err;
   logic [AW-1:0] base;
   logic [63:0] raw, ext;

   assign req_ready = reset && (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   // With LATENCY 1 the response is formed on the accept edge, so use live inputs.
   always_comb begin
      if (state == IDLE) begin
         cur_we    = req_we;
         cur_uns   = req_unsigned;
         cur_addr  = req_addr;
         cur_wdata = req_wdata;
         cur_size  = req_size;
      end else begin
         cur_we    = cap_we;
         cur_uns   = cap_uns;
         cur_addr  = cap_addr;
         cur_wdata = cap_wdata;
         cur_size  = cap_size;
      end
   end

   always_comb begin
      nbytes   = 4'd1 << cur_size;
      misal    = (cur_addr & {60'd0, nbytes - 4'd1}) != 64'd0;
      end_addr = {1'b0, cur_addr} + {61'd0, nbytes};
      oor      = end_addr > 65'(DEPTH_BYTES);
      err      = misal || oor;
      base     = cur_addr[AW-1:0];
   end

   always_comb begin
      raw = '0;
      for (int k = 0; k < 8; k++) begin
         if (k < int'(nbytes)) raw[8*k +: 8] = mem[base + AW'(k)];
      end
   end

   always_comb begin
      ext = raw;
      unique case (cur_size)
         2'd0: ext = cur_uns ? {56'd0, raw[7:0]}
                             : {{56{raw[7]}}, raw[7:0]};
         2'd1: ext = cur_uns ? {48'd0, raw[15:0]}
                             : {{48{raw[15]}}, raw[15:0]};
         2'd2: ext = cur_uns ? {32'd0, raw[31:0]}
                             : {{32{raw[31]}}, raw[31:0]};
         2'd3: ext = raw;
         default: ext = raw;
      endcase
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      enter_resp = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_nx   = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nx = WAIT;
                  cnt_nx   = 4'(LATENCY - 2);
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_nx   = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         cap_we    <= 1'b0;
         cap_uns   <= 1'b0;
         cap_addr  <= 64'd0;
         cap_wdata <= 64'd0;
         cap_size  <= 2'd0;
         rdata_q   <= 64'd0;
         err_q     <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            cap_we    <= req_we;
            cap_uns   <= req_unsigned;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_size  <= req_size;
         end
         if (enter_resp) begin
            rdata_q <= (err || cur_we) ? 64'd0 : ext;
            err_q   <= err;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'd0;
      end else if (enter_resp && cur_we && !err) begin
         for (int k = 0; k < 8; k++) begin
            if (k < int'(nbytes)) mem[base + AW'(k)] <= cur_wdata[8*k +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder (LATENCY 2 and 1).
module tb_data_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [63:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [63:0] rsp_rdata;

   logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
   logic [63:0] b_req_addr, b_req_wdata;
   logic [1:0]  b_req_size;
   logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [63:0] b_rsp_rdata;

   data_mem_responder #(.DEPTH_BYTES(256), .LATENCY(2)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   data_mem_responder #(.DEPTH_BYTES(256), .LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_we(b_req_we), .req_addr(b_req_addr),
      .req_size(b_req_size), .req_unsigned(b_req_unsigned),
      .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   typedef struct packed {
      logic        err;
      logic [63:0] data;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input string tag, input logic we,
                       input logic [63:0] a, input logic [1:0] sz,
                       input logic u, input logic [63:0] wd,
                       input logic [63:0] er, input logic ee,
                       input int hold);
      int   lat;
      exp_t e;
      q.push_back({ee, er});
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_addr     = a;
      req_size     = sz;
      req_unsigned = u;
      req_wdata    = wd;
      rsp_ready    = 1'b0;
      chk({tag, ".rdy"}, req_ready, 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = ~we;
      req_addr  = 64'hDEAD;
      req_size  = ~sz;
      req_wdata = '1;
      lat = 1;
      while (!rsp_valid && lat < 16) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, ".lat"}, lat, 2);
      chk({tag, ".vld"}, rsp_valid, 1);
      e = q.pop_front();
      chk({tag, ".data"}, rsp_rdata, e.data);
      chk({tag, ".err"}, rsp_err, e.err);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         req_valid = ~req_valid;
         req_we    = 1'b1;
         req_addr  = 64'h10;
         req_size  = 2'd3;
         req_wdata = 64'(i);
         @(posedge clk);
         #1;
         chk({tag, ".hold_vld"}, rsp_valid, 1);
         chk({tag, ".hold_data"}, rsp_rdata, e.data);
         chk({tag, ".hold_rdy"}, req_ready, 0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk({tag, ".done"}, rsp_valid, 0);
      chk({tag, ".idle"}, req_ready, 1);
   endtask

   initial begin
      exp_t e;
      reset        = 1'b0;
      req_valid    = 1'b1;
      req_we       = 1'b0;
      req_addr     = 64'd0;
      req_size     = 2'd0;
      req_unsigned = 1'b0;
      req_wdata    = 64'd0;
      rsp_ready    = 1'b0;
      b_req_valid  = 1'b0;
      b_req_we     = 1'b0;
      b_req_addr   = 64'd0;
      b_req_size   = 2'd0;
      b_req_unsigned = 1'b0;
      b_req_wdata  = 64'd0;
      b_rsp_ready  = 1'b0;

      #13;
      chk("rst.rdy", req_ready, 0);
      chk("rst.vld", rsp_valid, 0);
      chk("rst.data", rsp_rdata, 0);
      chk("rst.err", rsp_err, 0);
      @(negedge clk);
      req_valid = 1'b0;
      reset     = 1'b1;
      #1;
      chk("rst.rel_rdy", req_ready, 1);

      xfer("st_d10", 1, 64'h10, 3, 0, 64'h8877665544332211, 0, 0, 0);
      xfer("ld_b17", 0, 64'h17, 0, 0, 0, 64'hFFFFFFFFFFFFFF88, 0, 0);
      xfer("ld_hu16", 0, 64'h16, 1, 1, 0, 64'h8877, 0, 0);
      xfer("ld_hs16", 0, 64'h16, 1, 0, 0, 64'hFFFFFFFFFFFF8877, 0, 0);
      xfer("ld_ws10", 0, 64'h10, 2, 0, 0, 64'h44332211, 0, 0);
      xfer("st_df8", 1, 64'hF8, 3, 0, 64'h0123456789ABCDEF, 0, 0, 0);
      xfer("st_w12", 1, 64'h12, 2, 0, 64'hFFFFFFFF, 0, 1, 0);
      xfer("st_dfc", 1, 64'hFC, 3, 0, 64'hFFFFFFFFFFFFFFFF, 0, 1, 0);
      xfer("ld_df8", 0, 64'hF8, 3, 0, 0, 64'h0123456789ABCDEF, 0, 0);
      xfer("ld_ws10b", 0, 64'h10, 2, 0, 0, 64'h44332211, 0, 0);
      xfer("ld_wfc", 0, 64'hFC, 2, 0, 0, 64'h01234567, 0, 0);
      xfer("ld_b100", 0, 64'h100, 0, 1, 0, 0, 1, 0);
      xfer("ld_dwrap", 0, 64'hFFFFFFFFFFFFFFF8, 3, 0, 0, 0, 1, 0);
      xfer("hold", 0, 64'h10, 3, 0, 0, 64'h8877665544332211, 0, 5);
      xfer("ld_after_hold", 0, 64'h10, 3, 0, 0,
           64'h8877665544332211, 0, 0);

      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 64'h20;
      req_size  = 2'd0;
      req_wdata = 64'hAA;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("abort.wait", rsp_valid, 0);
      reset = 1'b0;
      #1;
      chk("abort.vld", rsp_valid, 0);
      chk("abort.rdy", req_ready, 0);
      chk("abort.data", rsp_rdata, 0);
      chk("abort.err", rsp_err, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort.no_rsp", rsp_valid, 0);
      xfer("ld_b20", 0, 64'h20, 0, 1, 0, 0, 0, 0);
      xfer("ld_d10_clr", 0, 64'h10, 3, 0, 0, 0, 0, 0);

      @(negedge clk);
      b_req_valid = 1'b1;
      b_req_we    = 1'b1;
      b_req_addr  = 64'h8;
      b_req_size  = 2'd3;
      b_req_wdata = 64'h55;
      b_rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("b2b.vld", b_rsp_valid, (i % 2) == 0);
         chk("b2b.rdy", b_req_ready, (i % 2) == 1);
         chk("b2b.data", b_rsp_rdata, 0);
      end
      @(negedge clk);
      b_req_we = 1'b0;
      q.push_back({1'b0, 64'h55});
      @(posedge clk);
      #1;
      chk("lat1.vld", b_rsp_valid, 1);
      e = q.pop_front();
      chk("lat1.data", b_rsp_rdata, e.data);
      chk("lat1.err", b_rsp_err, e.err);
      @(negedge clk);
      b_req_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
